serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high, sampled on rising edge of clk.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high while serial addition is in progress.
REQ-009 done  output  1  one-cycle pulse; sum/cout valid.
REQ-010 sum  output  WIDTH  result; held from done until the next accepted start.
REQ-011 cout  output  1  carry-out; same validity as sum.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at an edge: load a, b and cin into internal shift/carry registers, clear the bit counter, and go to SHIFT.
REQ-014 SHIFT: each cycle SHALL add operand LSBs plus the carry register in one full-adder cell, shift the sum bit into sum MSB-first (LSB-first arithmetic), shift the operands right, and register the carry-out.
REQ-015 SHIFT SHALL last exactly WIDTH cycles and then go to DONE; the counter width SHALL be clog2(WIDTH)+1.
REQ-016 done SHALL be high for exactly one cycle, WIDTH edges after the edge that accepted start; DONE then goes to IDLE unconditionally.
REQ-017 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-018 start SHALL be ignored in SHIFT and DONE; a start held high through DONE SHALL be accepted in the next IDLE cycle.
REQ-019 sum and cout SHALL equal (a + b + cin) mod 2^WIDTH and bit WIDTH of that sum; they SHALL change only during SHIFT and after reset.
REQ-020 a, b and cin changing after acceptance SHALL NOT affect the result.

Reset
REQ-021 rst=1 SHALL force IDLE and busy=0, done=0, sum=0, cout=0, clear the counter and the carry register, and clear ovf when compiled in. This holds in any state, including mid-SHIFT.
REQ-022 rst SHALL take priority over start at the same edge.

Configuration
REQ-023 Macro SERIAL_ADDER_OVF_EN SHALL add output ovf (1 bit), the two's-complement signed overflow (carry into MSB XOR carry out of MSB). Its validity and hold behaviour SHALL match sum.
REQ-024 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent, with all other behaviour unchanged.

Structure
REQ-025 Package serial_adder_pkg SHALL hold the FSM state enum and the WIDTH default constant.
REQ-026 The one-bit add SHALL be sub-module fa_cell (inputs x, y, ci; outputs s, co; combinational). Its two-half-adder-plus-OR structure SHALL be instantiated once.

Verification (WIDTH=8)
REQ-027 a=0x00, b=0x00, cin=0 -> after 8 edges: done=1, sum=0x00, cout=0; busy high for exactly 8 cycles.
REQ-028 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with the macro, ovf=0.
REQ-029 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0; with the macro, ovf=1.
REQ-030 a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then pulse start during SHIFT with a=0x01 -> ignored, result unchanged.
REQ-031 rst=1 for one cycle after the 3rd SHIFT cycle -> next cycle IDLE, busy=0, done=0, sum=0x00, cout=0. A new start then completes normally.
REQ-032 Hold start=1 continuously -> done pulses every 10 cycles (load, 8 SHIFT, DONE). Each result matches the reference model.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
//   state_t       : FSM state encoding (IDLE, SHIFT, DONE)
//   WIDTH_DEFAULT : default operand/sum width
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder built from two half adders and an OR.
//   x, y : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_cell
    import serial_adder_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;
    logic g0;
    logic g1;

    // First half adder on the operands, second folds in the carry.
    assign p  = x ^ y;
    assign g0 = x & y;
    assign s  = p ^ ci;
    assign g1 = p & ci;
    assign co = g0 | g1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, sampled only while idle
//   a, b  : operands, captured when start is accepted
//   cin   : carry in, captured when start is accepted
//   busy  : high while bits are being shifted
//   done  : one-cycle pulse when sum/cout are final
//   sum   : result, held until the next accepted start
//   cout  : carry out of the MSB
//   ovf   : two's-complement overflow (SERIAL_ADDER_OVF_EN only)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic               fa_s;
    logic               fa_co;
    logic               last_bit;
    logic               load;
    logic               step;
    logic               busy_d;
    logic               done_d;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    fa_cell u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/control decode; busy and done are registered from the next state.
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state)
            IDLE:    load = start;
            SHIFT:   step = 1'b1;
            default: ;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // Datapath: operand shifters, carry, counter and result registers.
    // sum/cout/ovf are only written while shifting so they hold through DONE/IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (load) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (step) begin
                a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                carry <= fa_co;
                sum   <= {fa_s, sum[WIDTH-1:1]};
                cout  <= fa_co;
                cnt   <= cnt + CNT_W'(1);
`ifdef SERIAL_ADDER_OVF_EN
                // On the final step carry holds the carry into the MSB.
                ovf   <= carry ^ fa_co;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with a transaction-level model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int t;
        t = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (t > 127) || (t < -128);
    endfunction

    // Model: ph = 0 idle, W..1 cycles of shifting left, -1 result cycle.
    int           m_ph   = 0;
    logic [W:0]   m_res  = '0;
    bit           m_ovp  = 0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    bit           m_ovf  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph   <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 0;
        end else if (m_ph == 0) begin
            if (start) begin
                m_ph  <= W;
                m_res <= (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
                m_ovp <= signed_ovf(a, b, cin);
            end
        end else if (m_ph > 1) begin
            m_ph <= m_ph - 1;
        end else if (m_ph == 1) begin
            m_ph   <= -1;
            m_sum  <= m_res[W-1:0];
            m_cout <= m_res[W];
            m_ovf  <= m_ovp;
        end else begin
            m_ph <= 0;
        end
    end

    // Per-cycle comparison; result outputs are checked whenever they must be stable.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_ph > 0));
            chk("done", 32'(done), 32'(m_ph == -1));
            if (m_ph <= 0) begin
                chk("sum", 32'(sum), 32'(m_sum));
                chk("cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
            end
        end
    end

    // One transaction with literal expectations; optional start pulse mid-shift.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo, input bit poke);
        int  nb;
        bit  found;
        @(negedge clk);
        a = ta; b = tb2; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        nb = 0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (done) begin
                found = 1;
            end else begin
                if (busy) nb++;
                if (poke) begin
                    if (i == 3) begin start = 1'b1; a = 8'h01; end
                    if (i == 4) start = 1'b0;
                end
                @(negedge clk);
            end
        end
        chk("done_seen", 32'(found), 32'd1);
        chk("busy_cycles", 32'(nb), 32'd8);
        chk("lit_sum", 32'(sum), 32'(es));
        chk("lit_cout", 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        chk("lit_ovf", 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected x flag");
`endif
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   rs;
        int           prev;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1);

        // Reset after the third shift cycle, with start also high at that edge.
        @(negedge clk);
        a = 8'h3C; b = 8'h11; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0);

        // Random operands with bench-computed expectations.
        for (int k = 0; k < 12; k++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            rs = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
            run_op(ra, rb, rc, rs[W-1:0], rs[W], signed_ovf(ra, rb, rc), k[0]);
        end

        // start held high: results back to back, one every 10 cycles.
        prev = -1;
        start = 1'b1;
        for (int i = 0; i < 55; i++) begin
            @(negedge clk);
            if (done) begin
                if (prev >= 0) chk("done_period", 32'(i - prev), 32'd10);
                prev = i;
            end
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        chk("period_seen", 32'(prev >= 0), 32'd1);
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
